vertical_fir_core: RTL and testbench

Vertical (column) pass of the separable 5-tap binomial denoising filter (1,4,6,4,1)/16. Consumes the raster-order pixel stream from the horizontal row-filter core and filters each column across five consecutive image lines using four on-chip line buffers. The output stream is 2-D filtered, ready for the frame writer. Output starts once four lines are primed; top and bottom border rows are dropped.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/vertical_fir_core_if.sv | 29 ++
 rtl/fir_line_buffer.sv | 24 ++
 rtl/vertical_fir_core.sv | 130 +++++++++++++
 tb/tb_vertical_fir_core.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the separable 5-tap binomial denoising filter.
// Used by both the horizontal and vertical filter cores.
package fir_pkg;

  localparam int C0         = 1;
  localparam int C1         = 4;
  localparam int C2         = 6;
  localparam int NORM_SHIFT = 4;
  localparam int TAPS       = 5;

  // Counter width for 0..n-1 columns; never less than one bit.
  function automatic int col_width(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/vertical_fir_core_if.sv
// Pixel stream bundle between the row filter, the column filter
// and the frame writer.
interface vertical_fir_core_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  valid_in;
  logic                  sof_in;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  valid_out;

  modport master (
    output pixel_in,
    output valid_in,
    output sof_in,
    input  pixel_out,
    input  valid_out
  );

  modport slave (
    input  pixel_in,
    input  valid_in,
    input  sof_in,
    output pixel_out,
    output valid_out
  );

endinterface

// File: rtl/fir_line_buffer.sv
// Four stacked line buffers packed into one word per column.
// Asynchronous read, synchronous write, storage is never reset.
module fir_line_buffer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [col_width(IMG_WIDTH)-1:0] addr_i,
  input  logic [4*DATA_WIDTH-1:0]     wdata_i,
  output logic [4*DATA_WIDTH-1:0]     rdata_o
);

  logic [4*DATA_WIDTH-1:0] mem [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/vertical_fir_core.sv
// Column pass of the (1,4,6,4,1)/16 filter over five image lines.
// Three register stages: partial sums, total, normalised output.
module vertical_fir_core
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512
) (
  input  logic           clk,
  input  logic           reset,
  vertical_fir_core_if.slave bus
);

  localparam int CW = col_width(IMG_WIDTH);
  localparam int SW = DATA_WIDTH + 4;
  localparam int TW = DATA_WIDTH + 6;
  localparam int LW = 4 * DATA_WIDTH;
  localparam logic [2:0]    ROW_FULL = 3'(TAPS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

  logic rst_n_q;
  logic rst_n;

  // Assert immediately, release on the next clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_n_q <= 1'b0;
    else        rst_n_q <= 1'b1;
  end

  assign rst_n = rst_n_q;

  logic [CW-1:0] col_q, col_d;
  logic [2:0]    rows_q, rows_d;
  logic          accept, sof;
  logic [CW-1:0] eff_col;
  logic [2:0]    eff_row;
  logic          last_col, qual;

  assign accept   = bus.valid_in;
  assign sof      = bus.valid_in & bus.sof_in;
  assign eff_col  = sof ? '0 : col_q;
  assign eff_row  = sof ? 3'd0 : rows_q;
  assign last_col = (eff_col == COL_LAST);
  assign qual     = accept & (eff_row == ROW_FULL);

  logic hold, restart, wrap, step;

  assign hold    = !accept;
  assign restart = sof;
  assign wrap    = accept & !sof & last_col;
  assign step    = accept & !sof & !last_col;

  always_comb begin
    col_d  = col_q;
    rows_d = rows_q;
    unique case (1'b1)
      hold: ;
      restart: begin
        col_d  = CW'(1);
        rows_d = 3'd0;
      end
      wrap: begin
        col_d  = '0;
        rows_d = (rows_q == ROW_FULL) ? ROW_FULL
                                      : rows_q + 3'd1;
      end
      step: col_d = col_q + CW'(1);
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0] lb1, lb2, lb3, lb4;
  logic [LW-1:0]         rd, wd;

  assign {lb1, lb2, lb3, lb4} = rd;
  assign wd = {bus.pixel_in, lb1, lb2, lb3};

  fir_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH)
  ) u_lb (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (eff_col),
    .wdata_i (wd),
    .rdata_o (rd)
  );

  logic [SW-1:0]         so_q, so_d;
  logic [SW-1:0]         si_q, si_d;
  logic [SW-1:0]         ce_q, ce_d;
  logic [TW-1:0]         tot_q, tot_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [2:0]            v_q;

  always_comb begin
    so_d  = SW'(bus.pixel_in) * SW'(C0)
          + SW'(lb4) * SW'(C0);
    si_d  = (SW'(lb1) + SW'(lb3)) * SW'(C1);
    ce_d  = SW'(lb2) * SW'(C2);
    tot_d = TW'(so_q) + TW'(si_q) + TW'(ce_q);
    out_d = DATA_WIDTH'(tot_q >> NORM_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      rows_q <= '0;
      so_q   <= '0;
      si_q   <= '0;
      ce_q   <= '0;
      tot_q  <= '0;
      out_q  <= '0;
      v_q    <= '0;
    end else begin
      col_q  <= col_d;
      rows_q <= rows_d;
      so_q   <= so_d;
      si_q   <= si_d;
      ce_q   <= ce_d;
      tot_q  <= tot_d;
      out_q  <= out_d;
      v_q    <= {v_q[1:0], qual};
    end
  end

  assign bus.pixel_out = out_q;
  assign bus.valid_out = v_q[2];

endmodule

// File: tb/tb_vertical_fir_core.sv
// Scoreboard bench for the column filter at IMG_WIDTH=4.
// Expected pixels come from a frame model kept by the bench.
module tb_vertical_fir_core;

  localparam int DW = 8;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vertical_fir_core_if #(.DATA_WIDTH(DW)) bus ();

  vertical_fir_core #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nout = 0;
  int first_cyc = -1;
  int acc16_cyc = -1;
  int n_acc = 0;
  int cur_row = 0;
  int cur_col = 0;
  int sb[$];
  int log_q[$];
  int img[0:15][0:W-1];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) begin : mon
        int got;
        int exp;
        got = int'(bus.pixel_out);
        log_q.push_back(got);
        nout++;
        if (first_cyc < 0) first_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0d, required no output at cycle %0d",
                   got, cyc);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL pixel_out: got %0d, required %0d at cycle %0d",
                     got, exp, cyc);
          end
        end
      end
    end
  end

  function automatic int model(input int r, input int c);
    return (img[r-4][c] + 4*img[r-3][c] + 6*img[r-2][c]
          + 4*img[r-1][c] + img[r][c]) >> 4;
  endfunction

  function automatic int pix_of(input int kind, input int r, input int c);
    case (kind)
      0: return 100;
      1: return 255;
      2: return (r == 2 && c == 1) ? 16 : 0;
      3: return 10 * r;
      default: return 50;
    endcase
  endfunction

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int pix, input bit sof, input int ovr);
    if (sof) begin
      cur_row = 0;
      cur_col = 0;
      n_acc   = 0;
    end
    img[cur_row][cur_col] = pix;
    if (cur_row >= 4)
      sb.push_back(ovr >= 0 ? ovr : model(cur_row, cur_col));
    bus.pixel_in = DW'(pix);
    bus.valid_in = 1'b1;
    bus.sof_in   = sof;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    n_acc++;
    if (n_acc == 16) acc16_cyc = cyc;
    if (cur_col == W - 1) begin
      cur_col = 0;
      cur_row++;
    end else begin
      cur_col++;
    end
  endtask

  task automatic send_frame(input int rows, input int kind,
                            input bit gaps, input int ovr);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++) begin
        send(pix_of(kind, r, c), (r == 0 && c == 0), ovr);
        if (gaps) idle($urandom_range(0, 3));
      end
  endtask

  task automatic test_reset();
    bus.pixel_in = '0;
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", bus.valid_out);
    end
    checks++;
    if (bus.pixel_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_pixel: got %0d, required 0", bus.pixel_out);
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_constant();
    int n0;
    n0 = nout;
    first_cyc = -1;
    send_frame(6, 0, 1'b0, 100);
    idle(5);
    checks++;
    if (nout - n0 != 8) begin
      errors++;
      $display("FAIL const_count: got %0d, required 8", nout - n0);
    end
    checks++;
    if (first_cyc != acc16_cyc + 3) begin
      errors++;
      $display("FAIL const_latency: got cycle %0d, required %0d",
               first_cyc, acc16_cyc + 3);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL const_pending: got %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_saturate();
    int n0;
    n0 = nout;
    send_frame(6, 1, 1'b0, 255);
    idle(5);
    checks++;
    if (nout - n0 != 8) begin
      errors++;
      $display("FAIL sat_count: got %0d, required 8", nout - n0);
    end
  endtask

  task automatic test_impulse();
    int rest;
    log_q.delete();
    send_frame(7, 2, 1'b0, -1);
    idle(5);
    checks++;
    if (log_q.size() != 12) begin
      errors++;
      $display("FAIL imp_count: got %0d, required 12", log_q.size());
    end else begin
      checks++;
      if (log_q[1] != 6 || log_q[5] != 4 || log_q[9] != 1) begin
        errors++;
        $display("FAIL imp_col1: got %0d %0d %0d, required 6 4 1",
                 log_q[1], log_q[5], log_q[9]);
      end
      rest = 0;
      for (int i = 0; i < 12; i++)
        if (i != 1 && i != 5 && i != 9) rest += log_q[i];
      checks++;
      if (rest != 0) begin
        errors++;
        $display("FAIL imp_others: got sum %0d, required 0", rest);
      end
    end
  endtask

  task automatic test_gaps();
    int ref_q[$];
    log_q.delete();
    send_frame(7, 3, 1'b0, -1);
    idle(5);
    ref_q = log_q;
    log_q.delete();
    send_frame(7, 3, 1'b1, -1);
    idle(5);
    checks++;
    if (ref_q.size() != 12 || ref_q[0] != 20) begin
      errors++;
      $display("FAIL ramp_ref: got %0d outputs first %0d, required 12 first 20",
               ref_q.size(), ref_q.size() > 0 ? ref_q[0] : -1);
    end
    checks++;
    if (log_q.size() != ref_q.size()) begin
      errors++;
      $display("FAIL gap_count: got %0d, required %0d",
               log_q.size(), ref_q.size());
    end else begin
      for (int i = 0; i < ref_q.size(); i++) begin
        checks++;
        if (log_q[i] != ref_q[i]) begin
          errors++;
          $display("FAIL gap_seq[%0d]: got %0d, required %0d",
                   i, log_q[i], ref_q[i]);
        end
      end
    end
  endtask

  task automatic test_sof_restart();
    int pend;
    int n0;
    send_frame(5, 3, 1'b0, -1);
    send(50, 1'b0, -1);
    send(60, 1'b0, -1);
    bus.sof_in   = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    bus.sof_in = 1'b0;
    pend = sb.size();
    n0 = nout;
    for (int i = 0; i < 16; i++) send(50, (i == 0), 50);
    checks++;
    if (nout - n0 != pend || sb.size() != 0) begin
      errors++;
      $display("FAIL sof_drain: got %0d outputs, required %0d", nout - n0, pend);
    end
    for (int i = 16; i < 24; i++) send(50, 1'b0, 50);
    idle(5);
    checks++;
    if (nout - n0 != pend + 8) begin
      errors++;
      $display("FAIL sof_new_count: got %0d, required %0d",
               nout - n0, pend + 8);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    for (int i = 0; i < 19; i++) send(100, (i == 0), 100);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.pixel_out !== 8'd100) begin
      errors++;
      $display("FAIL pre_reset: got valid %b pixel %0d, required 1 100",
               bus.valid_out, bus.pixel_out);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.pixel_out !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got valid %b pixel %0d, required 0 0",
               bus.valid_out, bus.pixel_out);
    end
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(3);
    n0 = nout;
    first_cyc = -1;
    send_frame(6, 0, 1'b0, 100);
    idle(5);
    checks++;
    if (first_cyc != acc16_cyc + 3) begin
      errors++;
      $display("FAIL reset_latency: got cycle %0d, required %0d",
               first_cyc, acc16_cyc + 3);
    end
    checks++;
    if (nout - n0 != 8) begin
      errors++;
      $display("FAIL reset_count: got %0d, required 8", nout - n0);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_saturate();
    test_impulse();
    test_gaps();
    test_sof_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
